// File: rtl/alu_mc_pkg.sv
// Shared opcode, flag-index and FSM-state constants for the multi-cycle ALU.
package alu_mc_pkg;

    localparam logic [2:0] ALU_OP_ADD = 3'd0;
    localparam logic [2:0] ALU_OP_SUB = 3'd1;
    localparam logic [2:0] ALU_OP_AND = 3'd2;
    localparam logic [2:0] ALU_OP_OR  = 3'd3;
    localparam logic [2:0] ALU_OP_XOR = 3'd4;
    localparam logic [2:0] ALU_OP_SHL = 3'd5;
    localparam logic [2:0] ALU_OP_SHR = 3'd6;
    localparam logic [2:0] ALU_OP_MUL = 3'd7;

    localparam int ALU_FLAG_ZERO     = 0;
    localparam int ALU_FLAG_NEGATIVE = 1;
    localparam int ALU_FLAG_CARRY    = 2;
    localparam int ALU_FLAG_OVERFLOW = 3;
    localparam int ALU_FLAG_PARITY   = 4;

    typedef enum logic [1:0] {
        ALU_ST_IDLE = 2'd0,
        ALU_ST_BUSY = 2'd1,
        ALU_ST_DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_mc_mul_step.sv
// One MSB-first shift-add multiplier step: acc_o = 2*acc_i + (bit_i ? mcand_i : 0).
// ovf_o flags any weight lost above bit AW-1, which feeds the sticky upper-half bit.
module alu_mul_step #(
    parameter int AW = 16,
    parameter int MW = 8
) (
    input  logic [AW-1:0] acc_i,
    input  logic [MW-1:0] mcand_i,
    input  logic          bit_i,
    output logic [AW-1:0] acc_o,
    output logic          ovf_o
);
    logic [AW:0] addend;
    logic [AW:0] sum;

    assign addend = {{(AW + 1 - MW){1'b0}}, (bit_i ? mcand_i : {MW{1'b0}})};
    assign sum    = {1'b0, acc_i[AW-2:0], 1'b0} + addend;
    assign acc_o  = sum[AW-1:0];
    assign ovf_o  = acc_i[AW-1] | sum[AW];
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready on both sides and an iterative shift-add multiplier.
// Define ALU_MUL_HI_EN to expose the upper product half on out_hi.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [7:0]       flags,
`ifdef ALU_MUL_HI_EN
    output logic [WIDTH-1:0] out_hi,
`endif
    output logic [1:0]       dbg_state_o
);
`ifdef ALU_MUL_HI_EN
    localparam int AW = 2 * WIDTH;
`else
    localparam int AW = WIDTH;
`endif

    alu_state_e       state_q;
    logic             in_ready_q, out_valid_q;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH-1:0] mcand_q, mplier_q, out_q;
    logic [AW-1:0]    acc_q;
    logic [7:0]       flags_q;
`ifdef ALU_MUL_HI_EN
    logic [WIDTH-1:0] hi_q;
`else
    logic             sticky_q;
`endif

    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;
    logic [WIDTH:0]   sum_ext, shl_ext, shr_ext;
    logic [AW-1:0]    step_acc;
    logic             step_ovf, mul_hi_nz;

    function automatic logic [7:0] pack_flags(input logic [WIDTH-1:0] r,
                                              input logic c, input logic v);
        logic [7:0] f;
        f = 8'h00;
        f[ALU_FLAG_ZERO]     = (r == '0);
        f[ALU_FLAG_NEGATIVE] = r[WIDTH-1];
        f[ALU_FLAG_CARRY]    = c;
        f[ALU_FLAG_OVERFLOW] = v;
        f[ALU_FLAG_PARITY]   = ^r;
        return f;
    endfunction

    // Single-cycle ops, evaluated straight from the input operands at accept.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        sum_ext = '0;
        shl_ext = '0;
        shr_ext = '0;
        case (op)
            ALU_OP_ADD: begin
                sum_ext = {1'b0, a} + {1'b0, b};
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_OP_SUB: begin
                sum_ext = {1'b0, a} - {1'b0, b};
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_OP_AND: alu_res = a & b;
            ALU_OP_OR:  alu_res = a | b;
            ALU_OP_XOR: alu_res = a ^ b;
            // One guard bit on each side captures the last bit shifted out.
            ALU_OP_SHL: begin
                shl_ext = {1'b0, a} << b[SHW-1:0];
                alu_res = shl_ext[WIDTH-1:0];
                alu_c   = shl_ext[WIDTH];
            end
            ALU_OP_SHR: begin
                shr_ext = {a, 1'b0} >> b[SHW-1:0];
                alu_res = shr_ext[WIDTH:1];
                alu_c   = shr_ext[0];
            end
            default: ;
        endcase
    end

    alu_mul_step #(.AW(AW), .MW(WIDTH)) u_step (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .bit_i   (mplier_q[cnt_q]),
        .acc_o   (step_acc),
        .ovf_o   (step_ovf)
    );

`ifdef ALU_MUL_HI_EN
    assign mul_hi_nz = (step_acc[AW-1:WIDTH] != '0) | step_ovf;
`else
    assign mul_hi_nz = sticky_q | step_ovf;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ALU_ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            flags_q     <= '0;
`ifdef ALU_MUL_HI_EN
            hi_q        <= '0;
`else
            sticky_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ALU_ST_IDLE: if (in_valid) begin
                    in_ready_q <= 1'b0;
                    if (op == ALU_OP_MUL) begin
                        state_q  <= ALU_ST_BUSY;
                        cnt_q    <= SHW'(WIDTH - 1);
                        mcand_q  <= a;
                        mplier_q <= b;
                        acc_q    <= '0;
`ifndef ALU_MUL_HI_EN
                        sticky_q <= 1'b0;
`endif
                    end else begin
                        state_q     <= ALU_ST_DONE;
                        out_valid_q <= 1'b1;
                        out_q       <= alu_res;
                        flags_q     <= pack_flags(alu_res, alu_c, alu_v);
`ifdef ALU_MUL_HI_EN
                        hi_q        <= '0;
`endif
                    end
                end
                // Multiplier bits are consumed MSB first, indexed by the down-counter.
                ALU_ST_BUSY: begin
                    acc_q <= step_acc;
`ifndef ALU_MUL_HI_EN
                    sticky_q <= sticky_q | step_ovf;
`endif
                    if (cnt_q == '0) begin
                        state_q     <= ALU_ST_DONE;
                        out_valid_q <= 1'b1;
                        out_q       <= step_acc[WIDTH-1:0];
                        flags_q     <= pack_flags(step_acc[WIDTH-1:0], mul_hi_nz, mul_hi_nz);
`ifdef ALU_MUL_HI_EN
                        hi_q        <= step_acc[AW-1:WIDTH];
`endif
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ALU_ST_DONE: if (out_ready) begin
                    state_q     <= ALU_ST_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
                default: begin
                    state_q     <= ALU_ST_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out         = out_q;
    assign flags       = flags_q;
    assign dbg_state_o = state_q;
`ifdef ALU_MUL_HI_EN
    assign out_hi      = hi_q;
`endif
endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=8): directed vectors, backpressure,
// mid-multiply reset and randomized traffic against an arithmetic reference model.
module tb_alu_mc;
    localparam int W  = 8;
    localparam int EW = 2 * W + 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] a, b, out;
    logic [2:0]   op;
    logic [7:0]   flags;
    logic [1:0]   dbg_state;
`ifdef ALU_MUL_HI_EN
    logic [W-1:0] out_hi;
`endif

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];

    alu_mc #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .op          (op),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out         (out),
        .flags       (flags),
`ifdef ALU_MUL_HI_EN
        .out_hi      (out_hi),
`endif
        .dbg_state_o (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: {hi, flags, out} from plain integer arithmetic.
    function automatic logic [EW-1:0] model(input logic [2:0] o, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
        longint ux, uy, full, hi;
        int sx, sy, sr, amt;
        logic c, v;
        logic [W-1:0] r;
        logic [7:0] f;
        ux = longint'(x); uy = longint'(y);
        sx = $signed(x); sy = $signed(y);
        amt = int'(y) % W;
        hi = 0; c = 1'b0; v = 1'b0; r = '0; full = 0; sr = 0;
        case (o)
            3'd0: begin
                full = ux + uy; r = W'(full); c = (full >= (64'd1 << W));
                sr = sx + sy; v = (sr > (2 ** (W - 1)) - 1) || (sr < -(2 ** (W - 1)));
            end
            3'd1: begin
                full = ux - uy; r = W'(full); c = (ux < uy);
                sr = sx - sy; v = (sr > (2 ** (W - 1)) - 1) || (sr < -(2 ** (W - 1)));
            end
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = x ^ y;
            3'd5: begin
                r = W'(ux << amt);
                c = (amt != 0) && (((ux >> (W - amt)) & 1) != 0);
            end
            3'd6: begin
                r = W'(ux >> amt);
                c = (amt != 0) && (((ux >> (amt - 1)) & 1) != 0);
            end
            default: begin
                full = ux * uy; r = W'(full); hi = full >> W;
                c = (hi != 0); v = c;
            end
        endcase
        f = {3'b000, 1'($countones(r) % 2), v, c, (r >= (1 << (W - 1))), (r == 0)};
        return {W'(hi), f, r};
    endfunction

    // Driver: wait for in_ready, present one operation for one cycle.
    task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int g = 0;
        while (!in_ready && g < 100) begin @(negedge clk); g++; end
        if (!in_ready) check("send_timeout", 0, 1);
        op = o; a = x; b = y; in_valid = 1'b1;
        exp_q.push_back(model(o, x, y));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Latency counts the accept edge as 1.
    task automatic wait_result(output int lat);
        lat = 1;
        while (!out_valid && lat < 60) begin
            check("busy_in_ready", in_ready, 0);
            @(negedge clk);
            lat++;
        end
        if (!out_valid) check("result_timeout", 0, 1);
    endtask

    // Scoreboard pop plus consumer handshake.
    task automatic collect(output logic [W-1:0] got_out, output logic [7:0] got_flg);
        logic [EW-1:0] e;
        got_out = out; got_flg = flags;
        if (exp_q.size() == 0) begin
            check("sb_underflow", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check("sb_out", out, e[W-1:0]);
            check("sb_flags", flags, e[W+7:W]);
`ifdef ALU_MUL_HI_EN
            check("sb_out_hi", out_hi, e[EW-1:W+8]);
`endif
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_in_ready", in_ready, 1);
        check("idle_out_valid", out_valid, 0);
    endtask

    logic [2:0]   d_op [6] = '{3'd0, 3'd0, 3'd1, 3'd5, 3'd6, 3'd7};
    logic [W-1:0] d_a  [6] = '{8'd200, 8'd127, 8'd5, 8'h81, 8'h01, 8'd16};
    logic [W-1:0] d_b  [6] = '{8'd100, 8'd1, 8'd5, 8'h09, 8'h00, 8'd20};
    logic [W-1:0] d_out[6] = '{8'd44, 8'd128, 8'd0, 8'h02, 8'h01, 8'd64};
    logic [7:0]   d_flg[6] = '{8'h14, 8'h1A, 8'h01, 8'h14, 8'h10, 8'h1C};

    initial begin
        int lat;
        logic [W-1:0] go, ra, rb;
        logic [7:0] gf, f0;
        logic [2:0] ro;

        // Reset
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out", out, 0);
        check("rst_flags", flags, 0);
`ifdef ALU_MUL_HI_EN
        check("rst_out_hi", out_hi, 0);
`endif

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            send(d_op[i], d_a[i], d_b[i]);
            wait_result(lat);
            check("dir_latency", lat, (d_op[i] == 3'd7) ? W + 1 : 1);
`ifdef ALU_MUL_HI_EN
            if (d_op[i] == 3'd7) check("dir_mul_hi", out_hi, 1);
`endif
            collect(go, gf);
            check("dir_out", go, d_out[i]);
            check("dir_flags", gf, d_flg[i]);
        end

        // Backpressure: held result, ignored in_valid pulses
        send(3'd0, 8'd1, 8'd2);
        wait_result(lat);
        f0 = flags;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; op = 3'($urandom_range(0, 7));
            a = W'($urandom); b = W'($urandom);
            @(negedge clk);
            in_valid = 1'b0;
            check("bp_out", out, 3);
            check("bp_flags", flags, f0);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
        end
        collect(go, gf);
        check("bp_final_flags", gf, 8'h00);
        repeat (3) begin
            @(negedge clk);
            check("bp_no_accept", out_valid, 0);
        end

        // Reset three cycles into a multiply
        send(3'd7, 8'd37, 8'd91);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        check("mrst_out_valid", out_valid, 0);
        check("mrst_in_ready", in_ready, 1);
        check("mrst_out", out, 0);
        check("mrst_flags", flags, 0);
        repeat (12) begin
            @(negedge clk);
            check("mrst_discarded", out_valid, 0);
        end
        send(3'd0, 8'd2, 8'd2);
        wait_result(lat);
        check("mrst_latency", lat, 1);
        collect(go, gf);
        check("mrst_add", go, 4);

        // Randomized traffic with random consumer stalls
        for (int i = 0; i < 150; i++) begin
            ro = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0: ra = 8'h00;
                1: ra = 8'hFF;
                2: ra = 8'h80;
                3: ra = 8'h7F;
                default: ra = W'($urandom);
            endcase
            rb = W'($urandom);
            send(ro, ra, rb);
            wait_result(lat);
            check("rnd_latency", lat, (ro == 3'd7) ? W + 1 : 1);
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                check("rnd_hold_valid", out_valid, 1);
            end
            collect(go, gf);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
